// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and reset defaults.
package fetch_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  // MOV R0,R0 -- harmless filler when a fetch is abandoned
  localparam logic [DATA_W-1:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Saturating wait-cycle counter; expired flags the last permitted WAIT cycle.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned      CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Holds at LAST rather than wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs a variable-latency request/ready handshake
// with instruction memory and stalls the controller until the word lands.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned       TIMEOUT   = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic [ADDR_W-1:0] PCNext,
  input  logic              IRWrite,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] Instr,
  output logic [ADDR_W-1:0] PC,
  output logic              FetchStall,
  output logic              FetchErr
);

  fetch_state_e      state, state_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] instr_d;
  logic [ADDR_W-1:0] pc_d;
  logic              err_d;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              expired;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      PC       <= RESET_PC;
      Instr    <= NOP_INSTR;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      FetchErr <= 1'b0;
    end else begin
      state    <= state_d;
      PC       <= pc_d;
      Instr    <= instr_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      FetchErr <= err_d;
    end
  end

  // Next-state and register update logic; ready beats timeout when both arrive
  always_comb begin
    state_d    = state;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    instr_d    = Instr;
    err_d      = FetchErr;
    pc_d       = PCWrite ? PCNext : PC;
    FetchStall = 1'b0;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;

    unique case (state)
      IDLE: begin
        FetchStall = IRWrite;
        if (IRWrite) begin
          state_d    = WAIT;
          mem_req_d  = 1'b1;
          mem_addr_d = PC;
        end
      end
      WAIT: begin
        FetchStall = 1'b1;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b1;
        if (mem_ready) begin
          instr_d   = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end else if (expired) begin
          instr_d   = NOP_INSTR;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: cycle table plus timeout/reset sequences.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic [31:0] PCNext;
  logic        IRWrite;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        FetchStall;
  logic        FetchErr;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .TIMEOUT   (16),
    .NOP_INSTR (32'hE1A0_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .PCNext     (PCNext),
    .IRWrite    (IRWrite),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .Instr      (Instr),
    .PC         (PC),
    .FetchStall (FetchStall),
    .FetchErr   (FetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for a cycle and outputs expected during that cycle
  typedef struct {
    logic        pcw;
    logic [31:0] pcn;
    logic        irw;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_stall;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic pcw, input logic [31:0] pcn, input logic irw,
                              input logic rdy, input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_stall);
    vec_t v;
    v.pcw = pcw; v.pcn = pcn; v.irw = irw; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCWrite = 1'b0; PCNext = 32'h0; IRWrite = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  // Request from IDLE, hold ready low for nwait WAIT cycles, then answer with data
  task automatic do_fetch(input int nwait, input logic [31:0] data);
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    for (int k = 0; k < nwait; k++) step();
    mem_ready = 1'b1; mem_rdata = data;
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    //      pcw pcn     irw rdy rdata          req addr    instr          pc      stall
    tbl[0]  = mk(0, 32'h00, 0, 0, 32'h0,        0, 32'h00, NOP,           32'h00, 0);
    tbl[1]  = mk(1, 32'h10, 0, 0, 32'h0,        0, 32'h00, NOP,           32'h00, 0);
    tbl[2]  = mk(0, 32'h00, 1, 0, 32'h0,        0, 32'h00, NOP,           32'h10, 1);
    tbl[3]  = mk(0, 32'h00, 1, 1, 32'hE2811001, 1, 32'h10, NOP,           32'h10, 1);
    tbl[4]  = mk(0, 32'h00, 1, 0, 32'h0,        0, 32'h10, 32'hE2811001, 32'h10, 0);
    tbl[5]  = mk(0, 32'h00, 0, 0, 32'h0,        0, 32'h10, 32'hE2811001, 32'h10, 0);
    tbl[6]  = mk(1, 32'h20, 0, 0, 32'h0,        0, 32'h10, 32'hE2811001, 32'h10, 0);
    tbl[7]  = mk(0, 32'h00, 1, 0, 32'h0,        0, 32'h10, 32'hE2811001, 32'h20, 1);
    tbl[8]  = mk(0, 32'h00, 0, 0, 32'h0,        1, 32'h20, 32'hE2811001, 32'h20, 1);
    tbl[9]  = mk(1, 32'h40, 0, 0, 32'h0,        1, 32'h20, 32'hE2811001, 32'h20, 1);
    tbl[10] = mk(0, 32'h00, 0, 0, 32'h0,        1, 32'h20, 32'hE2811001, 32'h40, 1);
    tbl[11] = mk(0, 32'h00, 0, 0, 32'h0,        1, 32'h20, 32'hE2811001, 32'h40, 1);
    tbl[12] = mk(0, 32'h00, 0, 0, 32'h0,        1, 32'h20, 32'hE2811001, 32'h40, 1);
    tbl[13] = mk(0, 32'h00, 0, 1, 32'hE3A01005, 1, 32'h20, 32'hE2811001, 32'h40, 1);
    tbl[14] = mk(0, 32'h00, 0, 0, 32'h0,        0, 32'h20, 32'hE3A01005, 32'h40, 0);
    tbl[15] = mk(0, 32'h00, 1, 0, 32'h0,        0, 32'h20, 32'hE3A01005, 32'h40, 1);
    tbl[16] = mk(0, 32'h00, 0, 1, 32'hE0822003, 1, 32'h40, 32'hE3A01005, 32'h40, 1);
    tbl[17] = mk(0, 32'h00, 0, 1, 32'hDEADBEEF, 0, 32'h40, 32'hE0822003, 32'h40, 0);
    tbl[18] = mk(0, 32'h00, 0, 1, 32'hDEADBEEF, 0, 32'h40, 32'hE0822003, 32'h40, 0);
    tbl[19] = mk(0, 32'h00, 0, 0, 32'h0,        0, 32'h40, 32'hE0822003, 32'h40, 0);

    // Reset held for two edges
    reset = 1'b0;
    idle_inputs();
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("reset_addr", mem_addr, 32'h0);
    chk("reset_err", 32'(FetchErr), 32'h0);
    step();

    // Zero-wait fetch, double-fetch guard, wait states and PCWrite mid-fetch
    for (int i = 0; i < NV; i++) begin
      PCWrite = tbl[i].pcw; PCNext = tbl[i].pcn; IRWrite = tbl[i].irw;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("row%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_instr", i), Instr, tbl[i].e_instr);
      chk($sformatf("row%0d_pc", i), PC, tbl[i].e_pc);
      chk($sformatf("row%0d_stall", i), 32'(FetchStall), 32'(tbl[i].e_stall));
      chk($sformatf("row%0d_err", i), 32'(FetchErr), 32'h0);
      step();
    end
    idle_inputs();

    // Timeout, with PCWrite coinciding with the request (old PC is fetched)
    IRWrite = 1'b1; PCWrite = 1'b1; PCNext = 32'h80;
    @(negedge clk);
    chk("to_req_stall", 32'(FetchStall), 32'h1);
    step();
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_req", k), 32'(mem_req), 32'h1);
      chk($sformatf("to_wait%0d_stall", k), 32'(FetchStall), 32'h1);
      chk($sformatf("to_wait%0d_addr", k), mem_addr, 32'h40);
      chk($sformatf("to_wait%0d_err", k), 32'(FetchErr), 32'h0);
      step();
    end
    @(negedge clk);
    chk("to_pc", PC, 32'h80);
    chk("to_instr", Instr, NOP);
    chk("to_err", 32'(FetchErr), 32'h1);
    chk("to_req", 32'(mem_req), 32'h0);
    chk("to_stall", 32'(FetchStall), 32'h0);
    step();

    // FetchErr stays set across a good fetch
    do_fetch(2, 32'hE5912000);
    @(negedge clk);
    chk("sticky_instr", Instr, 32'hE5912000);
    chk("sticky_err", 32'(FetchErr), 32'h1);
    step();

    // Reset clears the error; ready on the last allowed WAIT cycle wins over timeout
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_err", 32'(FetchErr), 32'h0);
    step();
    do_fetch(15, 32'hE1A0F00E);
    @(negedge clk);
    chk("tie_instr", Instr, 32'hE1A0F00E);
    chk("tie_err", 32'(FetchErr), 32'h0);
    chk("tie_stall", 32'(FetchStall), 32'h0);
    step();

    // Reset mid-fetch, then a stale ready must be ignored
    IRWrite = 1'b1;
    step();
    IRWrite = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("midrst_pre_req", 32'(mem_req), 32'h1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBADC0FFE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("midrst%0d_req", k), 32'(mem_req), 32'h0);
      chk($sformatf("midrst%0d_stall", k), 32'(FetchStall), 32'h0);
      chk($sformatf("midrst%0d_instr", k), Instr, NOP);
      chk($sformatf("midrst%0d_pc", k), PC, 32'h0);
      chk($sformatf("midrst%0d_err", k), 32'(FetchErr), 32'h0);
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the multicycle controller. It owns the PC and instruction registers and runs a variable-latency handshake with instruction memory. It presents the captured instruction word as Instr to the controller and decoder. FetchStall holds the controller's FETCH state until the word is captured.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum WAIT cycles before the fetch is aborted (must be at least 2).
NOP_INSTR, 32'hE1A0_0000, word substituted into Instr on timeout (MOV R0,R0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
PCWrite  in  1  from controller; load PC from PCNext.
PCNext  in  32  next PC (datapath Result).
IRWrite  in  1  from controller; request fetch of mem[PC] into Instr.
mem_req  out  1  instruction memory request, registered.
mem_addr  out  32  request address, registered, held stable while mem_req=1.
mem_rdata  in  32  memory read data, valid when mem_ready=1.
mem_ready  in  1  memory response strobe.
Instr  out  32  instruction register, to controller and datapath.
PC  out  32  program counter register.
FetchStall  out  1  to controller; hold FETCH state while high.
FetchErr  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0 at a clock edge):
  - PC=RESET_PC, Instr=NOP_INSTR, mem_req=0, mem_addr=0, FetchErr=0.
  - State goes to IDLE and the timeout counter clears.
  - Any in-flight transaction is abandoned; a late mem_ready is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With IRWrite=1 at edge t: mem_req=1 and mem_addr=PC (pre-edge value) from t+1; state goes to WAIT; counter=0.
  - FetchStall=IRWrite (combinational), so the controller stalls in the request cycle itself.
- WAIT:
  - mem_req=1 and FetchStall=1; the counter increments each cycle.
  - If mem_ready=1: Instr<=mem_rdata, mem_req<=0, state goes to DONE.
  - Else if counter==TIMEOUT-1: Instr<=NOP_INSTR, FetchErr<=1, mem_req<=0, state goes to DONE.
  - mem_ready and timeout in the same cycle: mem_ready wins and FetchErr is unchanged.
- DONE:
  - Lasts one cycle with FetchStall=0 so the controller advances. IRWrite is ignored here, which prevents a double fetch.
  - State then returns to IDLE.
- Minimum latency: IRWrite at edge t with mem_ready high in the first WAIT cycle gives Instr valid at t+2 and FetchStall low at t+2 (DONE).
- mem_ready outside WAIT is ignored.
- PC:
  - PCWrite=1 loads PCNext in any state, including WAIT.
  - An in-flight mem_addr is latched and unaffected.
  - PCWrite and an IRWrite start in the same cycle: the fetch uses the old PC and the PC updates.
- Instr changes only on capture, timeout or reset.
- FetchErr clears only on reset.
- The counter saturates and does not wrap.
- Width rules:
  - The counter is $clog2(TIMEOUT) bits.
  - All address and data paths are 32 bits.
  - PC is unaligned-tolerant; mem_addr passes PC unmodified.

Decomposition:
- Shared package fetch_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - the NOP_INSTR default;
  - the RESET_PC default.
- One sub-module, fetch_timeout_counter:
  - inputs: clear, enable;
  - output: expired;
  - parameterised by TIMEOUT, with the same clk and reset.
- FSM, PC and IR live in instr_fetch_unit.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> PC=0, Instr=32'hE1A00000, mem_req=0, FetchStall=0, FetchErr=0.
- Zero-wait fetch: PC=0x10, IRWrite=1 at edge t, mem_ready=1 with rdata=0xE2811001 in the first WAIT cycle -> mem_addr=0x10 at t+1, Instr=0xE2811001 at t+2, FetchStall low for exactly the DONE cycle, no second mem_req while IRWrite stays high in DONE.
- Wait states: mem_ready delayed 5 cycles -> mem_req and FetchStall high for 5 WAIT cycles, mem_addr stable, capture on the 6th.
- Timeout: TIMEOUT=16, mem_ready never asserted -> after 16 WAIT cycles Instr=0xE1A00000, FetchErr=1 and stays 1 across subsequent good fetches; mem_ready and timeout on the same cycle -> rdata captured, FetchErr=0.
- PCWrite during WAIT: PCNext=0x40 with PCWrite=1 mid-fetch from 0x20 -> mem_addr stays 0x20, PC=0x40 next cycle, next fetch addresses 0x40.
- Reset mid-fetch: reset=0 in WAIT, then a stale mem_ready after release -> state IDLE, mem_req=0, Instr=NOP_INSTR, stale data ignored.
